// File: rtl/i2c_reg_target_pkg.sv
// Shared types and constants for the I2C register target.
// FSM encoding, R/W bit values, register count and line-event bundle.
package i2c_reg_target_pkg;

    localparam int   I2C_NREGS    = 4;
    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK
    } i2c_state_t;

    typedef struct packed {
        logic sda;
        logic scl_rise;
        logic scl_fall;
        logic start;
        logic stop;
    } i2c_line_t;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/i2c_line_cond.sv
// SCL/SDA conditioning: 2-flop sync, optional majority filter, event detect.
// Define I2C_TGT_GLITCH_FILTER_EN to add the 3-sample filter (4 clk latency).
module i2c_line_cond
    import i2c_reg_target_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      scl_i,
    input  logic      sda_i,
    output i2c_line_t line_o
);

    logic [1:0] scl_sync_q, scl_sync_d;
    logic [1:0] sda_sync_q, sda_sync_d;
    logic       scl_c, sda_c;
    logic       scl_prev_q, sda_prev_q;

    always_comb begin
        scl_sync_d = {scl_sync_q[0], scl_i};
        sda_sync_d = {sda_sync_q[0], sda_i};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
        end
    end

`ifdef I2C_TGT_GLITCH_FILTER_EN
    logic [1:0] scl_win_q, scl_win_d;
    logic [1:0] sda_win_q, sda_win_d;
    logic       scl_flt_q, scl_flt_d;
    logic       sda_flt_q, sda_flt_d;

    always_comb begin
        scl_win_d = {scl_win_q[0], scl_sync_q[1]};
        sda_win_d = {sda_win_q[0], sda_sync_q[1]};
        scl_flt_d = maj3({scl_win_q, scl_sync_q[1]});
        sda_flt_d = maj3({sda_win_q, sda_sync_q[1]});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_win_q <= 2'b11;
            sda_win_q <= 2'b11;
            scl_flt_q <= 1'b1;
            sda_flt_q <= 1'b1;
        end else begin
            scl_win_q <= scl_win_d;
            sda_win_q <= sda_win_d;
            scl_flt_q <= scl_flt_d;
            sda_flt_q <= sda_flt_d;
        end
    end

    assign scl_c = scl_flt_q;
    assign sda_c = sda_flt_q;
`else
    assign scl_c = scl_sync_q[1];
    assign sda_c = sda_sync_q[1];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl_c;
            sda_prev_q <= sda_c;
        end
    end

    // START/STOP need SCL stable high across the SDA transition
    always_comb begin
        line_o.sda      = sda_c;
        line_o.scl_rise = scl_c & ~scl_prev_q;
        line_o.scl_fall = ~scl_c & scl_prev_q;
        line_o.start    = scl_c & scl_prev_q & sda_prev_q & ~sda_c;
        line_o.stop     = scl_c & scl_prev_q & ~sda_prev_q & sda_c;
    end

endmodule

// File: rtl/i2c_reg_target.sv
// I2C target exposing four 8-bit registers behind an auto-incrementing pointer.
// Optional input glitch filter: define I2C_TGT_GLITCH_FILTER_EN.
module i2c_reg_target
    import i2c_reg_target_pkg::*;
#(
    parameter logic [6:0]  TGT_ADDR = 7'h10,
    parameter logic [31:0] REG_INIT = 32'h78563412
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oen,
    input  logic [1:0] host_addr,
    output logic [7:0] host_rdata,
    output logic       wr_pulse,
    output logic       busy
);

    i2c_line_t ln;

    i2c_line_cond u_line (
        .clk   (clk),
        .rst   (rst),
        .scl_i (scl_i),
        .sda_i (sda_i),
        .line_o(ln)
    );

    i2c_state_t                     state_q, state_d;
    logic [3:0]                     cnt_q, cnt_d;
    logic [7:0]                     sh_q, sh_d;
    logic                           rw_q, rw_d;
    logic [1:0]                     ptr_q, ptr_d;
    logic [I2C_NREGS-1:0][7:0]      regs_q, regs_d;
    logic                           sda_oen_q, sda_oen_d;
    logic                           busy_q, busy_d;
    logic                           wr_pulse_q, wr_pulse_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sh_d       = sh_q;
        rw_d       = rw_q;
        ptr_d      = ptr_q;
        regs_d     = regs_q;
        sda_oen_d  = sda_oen_q;
        busy_d     = busy_q;
        wr_pulse_d = 1'b0;
        if (ln.stop) begin
            state_d   = ST_IDLE;
            sda_oen_d = 1'b1;
            busy_d    = 1'b0;
        end else if (ln.start) begin
            state_d   = ST_ADDR;
            cnt_d     = 4'd0;
            sh_d      = 8'h00;
            sda_oen_d = 1'b1;
        end else if (ln.scl_rise) begin
            if (state_q != ST_IDLE) begin
                sh_d  = {sh_q[6:0], ln.sda};
                cnt_d = cnt_q + 4'd1;
            end
        end else if (ln.scl_fall) begin
            // SDA only moves here, so it is stable while SCL is high
            unique case (state_q)
                ST_ADDR: begin
                    if (cnt_q == 4'd8) begin
                        cnt_d = 4'd0;
                        if (sh_q[7:1] == TGT_ADDR) begin
                            state_d   = ST_ADDR_ACK;
                            rw_d      = sh_q[0];
                            sda_oen_d = 1'b0;
                            busy_d    = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    cnt_d = 4'd0;
                    unique case (rw_q)
                        I2C_RW_WRITE: begin
                            state_d   = ST_PTR;
                            sda_oen_d = 1'b1;
                        end
                        I2C_RW_READ: begin
                            state_d   = ST_RDATA;
                            sda_oen_d = regs_q[ptr_q][7];
                        end
                        default: ;
                    endcase
                end
                ST_PTR: begin
                    if (cnt_q == 4'd8) begin
                        state_d   = ST_PTR_ACK;
                        ptr_d     = sh_q[1:0];
                        sda_oen_d = 1'b0;
                    end
                end
                ST_PTR_ACK, ST_WDATA_ACK: begin
                    state_d   = ST_WDATA;
                    cnt_d     = 4'd0;
                    sda_oen_d = 1'b1;
                end
                ST_WDATA: begin
                    if (cnt_q == 4'd8) begin
                        state_d       = ST_WDATA_ACK;
                        regs_d[ptr_q] = sh_q;
                        wr_pulse_d    = 1'b1;
                        ptr_d         = ptr_q + 2'd1;
                        sda_oen_d     = 1'b0;
                    end
                end
                ST_RDATA: begin
                    if (cnt_q == 4'd8) begin
                        state_d   = ST_RDATA_ACK;
                        ptr_d     = ptr_q + 2'd1;
                        sda_oen_d = 1'b1;
                    end else begin
                        sda_oen_d = regs_q[ptr_q][3'd7 - cnt_q[2:0]];
                    end
                end
                ST_RDATA_ACK: begin
                    cnt_d = 4'd0;
                    if (!sh_q[0]) begin
                        state_d   = ST_RDATA;
                        sda_oen_d = regs_q[ptr_q][7];
                    end else begin
                        state_d   = ST_IDLE;
                        sda_oen_d = 1'b1;
                        busy_d    = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            sh_q       <= 8'h00;
            rw_q       <= 1'b0;
            ptr_q      <= 2'd0;
            regs_q     <= REG_INIT;
            sda_oen_q  <= 1'b1;
            busy_q     <= 1'b0;
            wr_pulse_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            rw_q       <= rw_d;
            ptr_q      <= ptr_d;
            regs_q     <= regs_d;
            sda_oen_q  <= sda_oen_d;
            busy_q     <= busy_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    assign sda_oen    = sda_oen_q;
    assign busy       = busy_q;
    assign wr_pulse   = wr_pulse_q;
    assign host_rdata = regs_q[host_addr];

endmodule

// File: tb/tb_i2c_reg_target.sv
// Bench for i2c_reg_target: bit-banged master against a register/pointer model.
module tb_i2c_reg_target;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl;
    logic       sda_m;
    logic       sda_line;
    logic       sda_oen;
    logic [1:0] host_addr;
    logic [7:0] host_rdata;
    logic       wr_pulse;
    logic       busy;

    int n_pass  = 0;
    int n_total = 0;
    int wr_cnt  = 0;

    logic [7:0] m_regs [4];
    int         m_ptr;

    assign sda_line = sda_m & sda_oen;

    i2c_reg_target #(
        .TGT_ADDR(7'h10),
        .REG_INIT(32'h78563412)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl),
        .sda_i     (sda_line),
        .sda_oen   (sda_oen),
        .host_addr (host_addr),
        .host_rdata(host_rdata),
        .wr_pulse  (wr_pulse),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (wr_pulse) wr_cnt <= wr_cnt + 1;

    initial begin
        #5000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic wait_q();
        repeat (10) @(negedge clk);
    endtask

    task automatic model_reset();
        m_regs[0] = 8'h12;
        m_regs[1] = 8'h34;
        m_regs[2] = 8'h56;
        m_regs[3] = 8'h78;
        m_ptr     = 0;
    endtask

    task automatic do_reset();
        scl       = 1'b1;
        sda_m     = 1'b1;
        host_addr = 2'd0;
        rst       = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (6) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_q();
        scl   = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl   = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_q();
        scl   = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    wait_q();
        scl   = 1'b1; wait_q();
        scl   = 1'b0; wait_q();
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1; wait_q();
        scl   = 1'b1;
        repeat (5) @(negedge clk);
        b = sda_line;
        repeat (5) @(negedge clk);
        scl = 1'b0; wait_q();
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic nack);
        logic b;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            recv_bit(b);
            d = {d[6:0], b};
        end
        send_bit(nack);
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if (sda_oen !== 1'b1) $display("FAIL rst_sda_oen got %b exp 1", sda_oen);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy);
        else n_pass++;
        n_total++;
        if (wr_pulse !== 1'b0) $display("FAIL rst_wr_pulse got %b exp 0", wr_pulse);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            host_addr = 2'(i);
            #1;
            n_total++;
            if (host_rdata !== m_regs[i])
                $display("FAIL rst_reg%0d got %h exp %h", i, host_rdata, m_regs[i]);
            else n_pass++;
        end
    endtask

    task automatic test_write();
        logic ack;
        int   w0 = wr_cnt;
        i2c_start();
        send_byte(8'h20, ack);
        n_total++;
        if (ack !== 1'b0) $display("FAIL wr_addr_ack got %b exp 0", ack);
        else n_pass++;
        n_total++;
        if (busy !== 1'b1) $display("FAIL wr_busy got %b exp 1", busy);
        else n_pass++;
        send_byte(8'h02, ack);
        n_total++;
        if (ack !== 1'b0) $display("FAIL wr_ptr_ack got %b exp 0", ack);
        else n_pass++;
        send_byte(8'hA5, ack);
        n_total++;
        if (ack !== 1'b0) $display("FAIL wr_data_ack got %b exp 0", ack);
        else n_pass++;
        i2c_stop();
        m_regs[2] = 8'hA5;
        m_ptr     = 3;
        n_total++;
        if (wr_cnt - w0 != 1) $display("FAIL wr_pulses got %0d exp 1", wr_cnt - w0);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL wr_busy_end got %b exp 0", busy);
        else n_pass++;
        @(negedge clk);
        host_addr = 2'd2;
        #1;
        n_total++;
        if (host_rdata !== 8'hA5) $display("FAIL wr_reg2 got %h exp a5", host_rdata);
        else n_pass++;
    endtask

    task automatic test_read();
        logic       ack;
        logic [7:0] d;
        logic [7:0] exp_b;
        do_reset();
        i2c_start();
        send_byte(8'h21, ack);
        n_total++;
        if (ack !== 1'b0) $display("FAIL rd_addr_ack got %b exp 0", ack);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            exp_b = m_regs[m_ptr];
            m_ptr = (m_ptr + 1) % 4;
            recv_byte(d, k == 2);
            n_total++;
            if (d !== exp_b) $display("FAIL rd_byte%0d got %h exp %h", k, d, exp_b);
            else n_pass++;
        end
        n_total++;
        if (busy !== 1'b0) $display("FAIL rd_busy_nack got %b exp 0", busy);
        else n_pass++;
        n_total++;
        if (sda_oen !== 1'b1) $display("FAIL rd_sda_rel got %b exp 1", sda_oen);
        else n_pass++;
        i2c_stop();
    endtask

    task automatic test_wrap();
        logic ack;
        int   w0 = wr_cnt;
        i2c_start();
        send_byte(8'h20, ack);
        send_byte(8'h03, ack);
        send_byte(8'h11, ack);
        send_byte(8'h22, ack);
        n_total++;
        if (ack !== 1'b0) $display("FAIL wrap_ack got %b exp 0", ack);
        else n_pass++;
        i2c_stop();
        m_regs[3] = 8'h11;
        m_regs[0] = 8'h22;
        m_ptr     = 1;
        n_total++;
        if (wr_cnt - w0 != 2) $display("FAIL wrap_pulses got %0d exp 2", wr_cnt - w0);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            host_addr = 2'(i);
            #1;
            n_total++;
            if (host_rdata !== m_regs[i])
                $display("FAIL wrap_reg%0d got %h exp %h", i, host_rdata, m_regs[i]);
            else n_pass++;
        end
    endtask

    task automatic test_bad_addr();
        logic ack;
        int   w0 = wr_cnt;
        i2c_start();
        send_byte(8'h40, ack);
        n_total++;
        if (ack !== 1'b1) $display("FAIL bad_ack got %b exp 1", ack);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL bad_busy got %b exp 0", busy);
        else n_pass++;
        send_byte(8'h00, ack);
        send_byte(8'hFF, ack);
        n_total++;
        if (ack !== 1'b1) $display("FAIL bad_data_ack got %b exp 1", ack);
        else n_pass++;
        i2c_stop();
        n_total++;
        if (wr_cnt != w0) $display("FAIL bad_pulses got %0d exp 0", wr_cnt - w0);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            host_addr = 2'(i);
            #1;
            n_total++;
            if (host_rdata !== m_regs[i])
                $display("FAIL bad_reg%0d got %h exp %h", i, host_rdata, m_regs[i]);
            else n_pass++;
        end
    endtask

    task automatic test_repeated_start();
        logic       ack;
        logic [7:0] d;
        logic [7:0] exp_b;
        i2c_start();
        send_byte(8'h20, ack);
        send_byte(8'h01, ack);
        m_ptr = 1;
        i2c_start();
        send_byte(8'h21, ack);
        n_total++;
        if (ack !== 1'b0) $display("FAIL rs_addr_ack got %b exp 0", ack);
        else n_pass++;
        exp_b = m_regs[m_ptr];
        m_ptr = (m_ptr + 1) % 4;
        recv_byte(d, 1'b1);
        n_total++;
        if (d !== exp_b) $display("FAIL rs_byte got %h exp %h", d, exp_b);
        else n_pass++;
        i2c_stop();
    endtask

    task automatic test_stop_partial();
        logic       ack;
        logic [7:0] p;
        logic [7:0] d;
        int         w0 = wr_cnt;
        p = 8'($urandom);
        i2c_start();
        send_byte(8'h20, ack);
        send_byte(p, ack);
        m_ptr = int'(p[1:0]);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom));
        i2c_stop();
        n_total++;
        if (wr_cnt != w0) $display("FAIL part_pulses got %0d exp 0", wr_cnt - w0);
        else n_pass++;
        n_total++;
        if (sda_oen !== 1'b1) $display("FAIL part_sda got %b exp 1", sda_oen);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL part_busy got %b exp 0", busy);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            host_addr = 2'(i);
            #1;
            n_total++;
            if (host_rdata !== m_regs[i])
                $display("FAIL part_reg%0d got %h exp %h", i, host_rdata, m_regs[i]);
            else n_pass++;
        end
        d = 8'($urandom);
        i2c_start();
        send_byte(8'h20, ack);
        send_byte(8'h02, ack);
        send_byte(d, ack);
        n_total++;
        if (ack !== 1'b0) $display("FAIL part_next_ack got %b exp 0", ack);
        else n_pass++;
        i2c_stop();
        m_regs[2] = d;
        m_ptr     = 3;
        host_addr = 2'd2;
        #1;
        n_total++;
        if (host_rdata !== d) $display("FAIL part_next_reg got %h exp %h", host_rdata, d);
        else n_pass++;
    endtask

    task automatic test_rst_mid_read();
        logic       ack;
        logic       b;
        logic [7:0] d;
        logic [7:0] exp_b;
        int         w0;
        do_reset();
        w0 = wr_cnt;
        i2c_start();
        send_byte(8'h21, ack);
        recv_bit(b);
        recv_bit(b);
        n_total++;
        if (sda_oen !== 1'b0) $display("FAIL rmid_drive got %b exp 0", sda_oen);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_total++;
        if (sda_oen !== 1'b1) $display("FAIL rmid_sda got %b exp 1", sda_oen);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL rmid_busy got %b exp 0", busy);
        else n_pass++;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        sda_m = 1'b1; wait_q();
        scl   = 1'b1; wait_q();
        i2c_start();
        send_byte(8'h21, ack);
        n_total++;
        if (ack !== 1'b0) $display("FAIL rmid_next_ack got %b exp 0", ack);
        else n_pass++;
        exp_b = m_regs[m_ptr];
        m_ptr = (m_ptr + 1) % 4;
        recv_byte(d, 1'b1);
        n_total++;
        if (d !== exp_b) $display("FAIL rmid_next_byte got %h exp %h", d, exp_b);
        else n_pass++;
        i2c_stop();
        n_total++;
        if (wr_cnt != w0) $display("FAIL rmid_pulses got %0d exp 0", wr_cnt - w0);
        else n_pass++;
    endtask

    task automatic test_random();
        logic       ack;
        logic [7:0] d;
        logic [7:0] exp_b;
        logic [7:0] p;
        int         n;
        int         w0;
        for (int t = 0; t < 8; t++) begin
            n  = int'($urandom_range(1, 3));
            w0 = wr_cnt;
            i2c_start();
            if ($urandom_range(0, 1) == 0) begin
                p = 8'($urandom);
                send_byte(8'h20, ack);
                send_byte(p, ack);
                m_ptr = int'(p[1:0]);
                for (int k = 0; k < n; k++) begin
                    d = 8'($urandom);
                    send_byte(d, ack);
                    n_total++;
                    if (ack !== 1'b0) $display("FAIL rnd%0d_wack got %b exp 0", t, ack);
                    else n_pass++;
                    m_regs[m_ptr] = d;
                    m_ptr = (m_ptr + 1) % 4;
                end
                i2c_stop();
                n_total++;
                if (wr_cnt - w0 != n)
                    $display("FAIL rnd%0d_pulses got %0d exp %0d", t, wr_cnt - w0, n);
                else n_pass++;
            end else begin
                send_byte(8'h21, ack);
                for (int k = 0; k < n; k++) begin
                    exp_b = m_regs[m_ptr];
                    m_ptr = (m_ptr + 1) % 4;
                    recv_byte(d, k == n - 1);
                    n_total++;
                    if (d !== exp_b) $display("FAIL rnd%0d_rd got %h exp %h", t, d, exp_b);
                    else n_pass++;
                end
                i2c_stop();
            end
            for (int i = 0; i < 4; i++) begin
                host_addr = 2'(i);
                #1;
                n_total++;
                if (host_rdata !== m_regs[i])
                    $display("FAIL rnd%0d_reg%0d got %h exp %h", t, i, host_rdata, m_regs[i]);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_wrap();
        test_bad_addr();
        test_repeated_start();
        test_stop_partial();
        test_rst_mid_read();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
